// File: rtl/seg_conv_scheduler.sv
// seg_conv_scheduler: round-robin scheduler sharing one binary-to-BCD converter among four
// display channels, storing each channel's digits for combinational readout.
module seg_conv_scheduler #(
    parameter int CONV_TIMEOUT = 16383
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [55:0] value,
    output logic [3:0]  ack,
    output logic        conv_start,
    output logic [13:0] conv_number,
    input  logic        conv_done,
    input  logic [15:0] conv_digits,
    input  logic [1:0]  disp_sel,
    output logic [15:0] disp_digits,
    output logic        busy,
    output logic [3:0]  ovf,
    output logic        timeout_err
);
    localparam int CW = $clog2(CONV_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

    state_t        state;
    logic [1:0]    last_grant;
    logic [1:0]    grant;
    logic [1:0]    pick;
    logic [1:0]    cand;
    logic [CW-1:0] wait_cnt;
    logic [13:0]   pick_value;
    logic          pick_ovf;
    logic [15:0]   result [4];

    // Nearest requester after last_grant wins; iterating farthest-first lets the nearest overwrite.
    always_comb begin
        pick = last_grant;
        cand = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_grant + k[1:0];
            if (req[cand]) pick = cand;
        end
    end

    assign pick_value  = value[14*pick +: 14];
    assign pick_ovf    = pick_value > 14'd9999;
    assign disp_digits = result[disp_sel];
    assign busy        = state != IDLE;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 2'd3;
            grant       <= 2'd0;
            wait_cnt    <= '0;
            conv_start  <= 1'b0;
            conv_number <= 14'd0;
            ack         <= 4'd0;
            ovf         <= 4'd0;
            timeout_err <= 1'b0;
            for (int i = 0; i < 4; i++) result[i] <= 16'h0000;
        end else begin
            conv_start <= 1'b0;
            ack        <= 4'd0;
            case (state)
                IDLE: if (|req) begin
                    grant       <= pick;
                    conv_number <= pick_ovf ? 14'd9999 : pick_value;
                    ovf[pick]   <= pick_ovf;
                    conv_start  <= 1'b1;
                    state       <= START;
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                // First WAIT cycle ignores done so a level left high by the previous conversion is not taken.
                WAIT: if (wait_cnt != '0 && conv_done) begin
                    result[grant] <= conv_digits;
                    ack[grant]    <= 1'b1;
                    state         <= STORE;
                end else if (wait_cnt == CW'(CONV_TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    last_grant  <= grant;
                    state       <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                STORE: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_conv_scheduler.sv
// tb_seg_conv_scheduler: directed bench with a transaction-level model of arbitration,
// operand clamping and stored digits, plus a short-timeout instance for the abandon path.
module tb_seg_conv_scheduler;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req = '0;
    logic [55:0] value = '0;
    logic [3:0]  ack;
    logic        conv_start;
    logic [13:0] conv_number;
    logic        conv_done = 1'b0;
    logic [15:0] conv_digits = '0;
    logic [1:0]  disp_sel = '0;
    logic [15:0] disp_digits;
    logic        busy;
    logic [3:0]  ovf;
    logic        timeout_err;

    logic [3:0]  req_t = '0;
    logic [55:0] value_t = '0;
    logic [3:0]  ack_t;
    logic        conv_start_t;
    logic [13:0] conv_number_t;
    logic        conv_done_t = 1'b0;
    logic [15:0] conv_digits_t = '0;
    logic [1:0]  disp_sel_t = '0;
    logic [15:0] disp_digits_t;
    logic        busy_t;
    logic [3:0]  ovf_t;
    logic        timeout_err_t;

    int n_tests = 0;
    int n_fail = 0;
    int n_start = 0;
    int n_ack = 0;
    int conv_delay = 3;
    bit stale_mode = 0;
    int log_q[$];
    int exp_rr[5] = '{0, 1, 2, 3, 0};

    logic [15:0] m_res [4];
    logic [3:0]  m_ovf = '0;
    int          m_lg = 3;
    int          m_ch = 0;
    logic [13:0] m_op = '0;
    bit          in_conv = 0;
    logic [3:0]  req_d = '0;
    logic [55:0] value_d = '0;

    always #10 clock = ~clock;

    seg_conv_scheduler dut (
        .clock(clock), .reset_n(reset_n), .req(req), .value(value), .ack(ack),
        .conv_start(conv_start), .conv_number(conv_number), .conv_done(conv_done),
        .conv_digits(conv_digits), .disp_sel(disp_sel), .disp_digits(disp_digits),
        .busy(busy), .ovf(ovf), .timeout_err(timeout_err)
    );

    seg_conv_scheduler #(.CONV_TIMEOUT(20)) dut_t (
        .clock(clock), .reset_n(reset_n), .req(req_t), .value(value_t), .ack(ack_t),
        .conv_start(conv_start_t), .conv_number(conv_number_t), .conv_done(conv_done_t),
        .conv_digits(conv_digits_t), .disp_sel(disp_sel_t), .disp_digits(disp_digits_t),
        .busy(busy_t), .ovf(ovf_t), .timeout_err(timeout_err_t)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int n);
        return 16'(((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + n % 10);
    endfunction

    function automatic int rr(input logic [3:0] r, input int lg);
        for (int i = 1; i <= 4; i++) if (r[(lg + i) % 4]) return (lg + i) % 4;
        return -1;
    endfunction

    // Shared converter: done after conv_delay cycles; in stale mode the old done level lingers two cycles.
    initial begin
        int cnt, hold;
        logic [13:0] num;
        cnt = 0;
        hold = 0;
        num = '0;
        forever begin
            @(negedge clock);
            if (conv_start) begin
                num = conv_number;
                cnt = conv_delay;
                hold = stale_mode ? 2 : 0;
                if (!stale_mode) conv_done = 1'b0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) conv_done = 1'b0;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        conv_done = 1'b1;
                        conv_digits = bcd(num);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        int ch, v;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) m_res[i] = 16'h0000;
            m_ovf = '0;
            m_lg = 3;
            in_conv = 0;
            chk("rst_ctrl", {conv_start, ack, busy, timeout_err}, 0);
            chk("rst_num", conv_number, 0);
            chk("rst_ovf", ovf, 0);
        end else begin
            if (conv_start) begin
                ch = rr(req_d, m_lg);
                chk("grant_valid", 32'(ch >= 0), 1);
                if (ch < 0) ch = 0;
                v = int'(value_d[14*ch +: 14]);
                m_op = v > 9999 ? 14'd9999 : 14'(v);
                m_ovf[ch] = v > 9999;
                m_ch = ch;
                in_conv = 1;
                n_start++;
                chk("start_busy", busy, 1);
            end
            if (in_conv) chk("conv_number", conv_number, m_op);
            if (ack != 0) begin
                chk("ack_chan", ack, 32'(1 << m_ch));
                chk("ack_in_conv", in_conv, 1);
                chk("ack_no_start", conv_start, 0);
                chk("ack_busy", busy, 1);
                m_res[m_ch] = bcd(int'(m_op));
                m_lg = m_ch;
                in_conv = 0;
                n_ack++;
                log_q.push_back(m_ch);
            end
            chk("ovf", ovf, m_ovf);
            chk("timeout_err", timeout_err, 0);
            chk("disp", disp_digits, m_res[disp_sel]);
        end
        req_d = req;
        value_d = value;
    end

    task automatic wait_acks(input int n, input int bound, input string nm);
        int c = 0;
        while (n_ack < n && c < bound) begin
            @(posedge clock);
            c++;
        end
        #1;
        chk({"wait_ack_", nm}, 32'(n_ack >= n), 1);
    endtask

    task automatic wait_starts(input int n, input int bound, input string nm);
        int c = 0;
        while (n_start < n && c < bound) begin
            @(posedge clock);
            c++;
        end
        #1;
        chk({"wait_start_", nm}, 32'(n_start >= n), 1);
    endtask

    task automatic show(input logic [1:0] sel, input logic [15:0] exp, input string nm);
        @(posedge clock);
        #1 disp_sel = sel;
        @(negedge clock);
        chk(nm, disp_digits, exp);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int c;
        bit got_ack;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        chk("rst_disp_lit", disp_digits, 16'h0000);
        chk("rst_busy_lit", busy, 0);

        conv_delay = 3;
        value = {14'd40, 14'd30, 14'd20, 14'd10};
        req = 4'b1111;
        wait_acks(5, 200, "rr");
        req = 4'b0000;
        chk("rr_len", log_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_order", i < log_q.size() ? log_q[i] : -1, exp_rr[i]);
        show(2'd3, 16'h0040, "rr_disp3");
        show(2'd0, 16'h0010, "rr_disp0");

        n_start = 0;
        n_ack = 0;
        conv_delay = 1235;
        value[13:0] = 14'd1234;
        req = 4'b0001;
        wait_starts(1, 20, "single");
        req = 4'b0000;
        wait_acks(1, 1300, "single");
        repeat (10) @(posedge clock);
        #1;
        chk("single_starts", n_start, 1);
        chk("single_acks", n_ack, 1);
        chk("single_num", conv_number, 1234);
        show(2'd0, 16'h1234, "single_disp");

        n_start = 0;
        n_ack = 0;
        conv_delay = 4;
        value[41:28] = 14'd12000;
        req = 4'b0100;
        wait_starts(1, 20, "ovf");
        req = 4'b0000;
        chk("ovf_num", conv_number, 9999);
        chk("ovf_set", ovf[2], 1);
        wait_acks(1, 30, "ovf");
        show(2'd2, 16'h9999, "ovf_disp");
        value[41:28] = 14'd42;
        req = 4'b0100;
        wait_starts(2, 20, "ovf_clr");
        req = 4'b0000;
        chk("ovf_clear", ovf[2], 0);
        wait_acks(2, 30, "ovf_clr");
        show(2'd2, 16'h0042, "ovf_clr_disp");

        n_start = 0;
        n_ack = 0;
        stale_mode = 1;
        conv_delay = 6;
        value[27:14] = 14'd555;
        req = 4'b0010;
        wait_starts(1, 20, "stale");
        req = 4'b0000;
        wait_acks(1, 30, "stale");
        stale_mode = 0;
        chk("stale_acks", n_ack, 1);
        show(2'd1, 16'h0555, "stale_disp");

        n_start = 0;
        n_ack = 0;
        conv_delay = 50;
        value[55:42] = 14'd3333;
        req = 4'b1000;
        wait_starts(1, 20, "rst_mid");
        req = 4'b0000;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (80) @(posedge clock);
        #1;
        chk("rst_mid_noack", n_ack, 0);
        chk("rst_mid_busy", busy, 0);
        for (int s = 0; s < 4; s++) show(2'(s), 16'h0000, "rst_mid_disp");

        n_start = 0;
        n_ack = 0;
        conv_delay = 4;
        value[13:0] = 14'd7;
        req = 4'b0001;
        wait_starts(1, 20, "recover");
        req = 4'b0000;
        wait_acks(1, 30, "recover");
        show(2'd0, 16'h0007, "recover_disp");

        value_t[27:14] = 14'd77;
        req_t = 4'b0010;
        c = 0;
        while (!conv_start_t && c < 50) begin
            @(negedge clock);
            c++;
        end
        chk("to_start", conv_start_t, 1);
        chk("to_num", conv_number_t, 77);
        req_t = 4'b0000;
        got_ack = 0;
        repeat (20) begin
            @(negedge clock);
            got_ack |= ack_t != 0;
        end
        chk("to_busy_last_wait", busy_t, 1);
        chk("to_err_early", timeout_err_t, 0);
        @(negedge clock);
        got_ack |= ack_t != 0;
        chk("to_idle", busy_t, 0);
        chk("to_err", timeout_err_t, 1);
        chk("to_no_ack", got_ack, 0);

        value_t[41:28] = 14'd55;
        req_t = 4'b0100;
        c = 0;
        while (!conv_start_t && c < 50) begin
            @(negedge clock);
            c++;
        end
        chk("to_next_start", conv_start_t, 1);
        req_t = 4'b0000;
        @(negedge clock);
        conv_done_t = 1'b1;
        conv_digits_t = 16'h0055;
        c = 0;
        while (ack_t == 0 && c < 20) begin
            @(negedge clock);
            c++;
        end
        chk("to_next_ack", ack_t, 4'b0100);
        disp_sel_t = 2'd2;
        #1;
        chk("to_next_disp", disp_digits_t, 16'h0055);
        chk("to_next_num", conv_number_t, 55);
        chk("to_err_sticky", timeout_err_t, 1);
        chk("to_ovf", ovf_t, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end
endmodule
